sprite_draw_scheduler: RTL and testbench
========================================

Name: sprite_draw_scheduler

Overview:
- Shares the single VGA adapter write port among NUM_SRC sprite plotters (user, alien block, bullets, ...).
- Once per frame it grants each requesting plotter in turn and drives its plot enable.
- While a plotter is granted, its x/y/colour/plot outputs are muxed onto the VGA port.
- Sits between the per-sprite FSMs and the VGA adapter; top level supplies frame_tick.

Parameters:
- NUM_SRC, 4: number of sprite plotters; index 0 has highest priority.
- GRANT_TIMEOUT, 1023: maximum cycles a single grant may last before it is aborted.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- frame_tick  in  1  one-cycle pulse, start of frame redraw
- req  in  NUM_SRC  per-source redraw request, level
- src_done  in  NUM_SRC  per-source done pulse from plotter
- src_x  in  9*NUM_SRC  flattened x buses, source i at [9i+8:9i]
- src_y  in  8*NUM_SRC  flattened y buses, source i at [8i+7:8i]
- src_colour  in  3*NUM_SRC  flattened colour buses, source i at [3i+2:3i]
- src_plot  in  NUM_SRC  per-source pixel write strobe
- grant  out  NUM_SRC  one-hot enable to the plotter (its enable/should_plot input)
- vga_x  out  9  to VGA adapter
- vga_y  out  8  to VGA adapter
- vga_colour  out  3  to VGA adapter
- vga_plot  out  1  VGA write enable
- busy  out  1  high from frame start until frame_done
- frame_done  out  1  one-cycle pulse when all pending sources are served
- overrun  out  1  one-cycle pulse: frame_tick arrived while busy
- timeout_err  out  1  sticky; set on any aborted grant

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. All outputs 0, state S_IDLE, pending mask 0, timeout_err cleared. Reset mid-grant drops grant on the next edge.
- States: S_IDLE, S_CLEAR (optional), S_SCAN, S_GRANT, S_DONE.
- S_IDLE:
  - On frame_tick, latch pending <= req.
  - Go to S_CLEAR if enabled, else S_SCAN.
- S_SCAN (one cycle):
  - If pending == 0, go to S_DONE.
  - Otherwise select the lowest set index k, load the watchdog with 0, and go to S_GRANT.
- S_GRANT:
  - grant = one-hot(k).
  - vga_x/y/colour/plot are driven combinationally from source k (zero-latency mux).
  - If src_done[k]=1: pass through that cycle's outputs, clear pending[k], go to S_SCAN. grant is low the following cycle.
  - If the watchdog reaches GRANT_TIMEOUT without src_done[k]: clear pending[k], set timeout_err, go to S_SCAN.
  - src_done/src_plot from non-granted sources are ignored.
- S_DONE: frame_done=1 for one cycle, then S_IDLE.
- Outside S_GRANT/S_CLEAR: vga_plot=0 and vga_x/y/colour=0.
- busy = (state != S_IDLE).
- Latency (clear disabled): tick at cycle t, grant at t+2.
  - Each additional source adds exactly one S_SCAN cycle of gap.
  - With no requests: frame_done pulses at t+2.
- frame_tick while busy: ignored, overrun pulses the same cycle, the current frame continues.
- req changes after the snapshot are ignored until the next frame_tick.
- A request deasserted after the snapshot is still served.

Optional Feature:
- Macro: SPRITE_DRAW_CLEAR_EN.
- Defined:
  - After the snapshot, S_CLEAR sweeps vga_x 0..319 (inner) and vga_y 0..239 (outer).
  - vga_plot=1 and vga_colour=3'b000 throughout: 76800 cycles.
  - Then go to S_SCAN.
  - grant stays 0 during the sweep.
- Not defined: S_CLEAR and its counters are absent; S_IDLE goes directly to S_SCAN.

Test Plan:
- Two sources requesting, NUM_SRC=4, req=4'b0101, frame tick at cycle 10:
  - grant=0001 at cycle 12; src_done[0] at cycle 20; grant=0100 at cycle 22.
  - src_done[2] at cycle 30; frame_done at cycle 32.
  - vga_* mirrors src0 during cycles 12-20 and src2 during cycles 22-30.
- No requests, req=0: tick at cycle 5 -> frame_done at cycle 7, grant never asserted, vga_plot stays 0.
- Timeout: req=4'b0010, source never asserts done, GRANT_TIMEOUT=1023 -> grant drops after 1023 grant cycles, timeout_err=1 and stays set, frame_done follows.
- Tick while busy: second frame_tick during a grant -> overrun one-cycle pulse, the grant sequence is unaffected, and exactly one frame_done results.
- Isolation and reset: src_plot[3]=1 while source 1 is granted -> vga reflects source 1 only. resetn=0 mid-grant -> grant=0, busy=0, timeout_err=0 on the next edge.
- With SPRITE_DRAW_CLEAR_EN and req=4'b0001:
  - 76800 plot cycles at colour 0, last pixel (319,239).
  - Then grant=0001 two cycles later.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_draw_scheduler
//
// Shares the single VGA adapter write port among NUM_SRC sprite plotters.
// On each frame_tick it takes a snapshot of the per-source redraw requests.
// It then grants each pending source in turn, lowest index first. While a
// source holds the grant, its x/y/colour/plot outputs are muxed onto the VGA
// port with no added latency. A watchdog aborts any grant that runs for
// GRANT_TIMEOUT cycles without a done pulse.
//
// Optional feature (macro SPRITE_DRAW_CLEAR_EN): after the snapshot, the whole
// 320x240 screen is swept with colour 0 before any source is granted.
//
// Parameters
//   NUM_SRC        number of sprite plotters (index 0 = highest priority)
//   GRANT_TIMEOUT  maximum number of cycles a single grant may last
//
// Ports
//   clk          system clock
//   resetn       synchronous active-low reset
//   frame_tick   one-cycle pulse marking the start of a frame redraw
//   req          per-source redraw request (level, sampled on frame_tick)
//   src_done     per-source done pulse from the plotter
//   src_x        flattened 9-bit x buses, source i at [9i+8:9i]
//   src_y        flattened 8-bit y buses, source i at [8i+7:8i]
//   src_colour   flattened 3-bit colour buses, source i at [3i+2:3i]
//   src_plot     per-source pixel write strobe
//   grant        one-hot enable back to the granted plotter
//   vga_x/y/colour/plot  VGA adapter write port
//   busy         high while a frame is being processed
//   frame_done   one-cycle pulse when all snapshot sources have been served
//   overrun      one-cycle pulse when frame_tick arrives while busy
//   timeout_err  sticky flag, set when any grant is aborted
// -----------------------------------------------------------------------------
module sprite_draw_scheduler #(
  parameter int NUM_SRC       = 4,
  parameter int GRANT_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 frame_tick,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [NUM_SRC-1:0]   src_done,
  input  logic [9*NUM_SRC-1:0] src_x,
  input  logic [8*NUM_SRC-1:0] src_y,
  input  logic [3*NUM_SRC-1:0] src_colour,
  input  logic [NUM_SRC-1:0]   src_plot,
  output logic [NUM_SRC-1:0]   grant,
  output logic [8:0]           vga_x,
  output logic [7:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WD_W  = $clog2(GRANT_TIMEOUT + 1);
  // The watchdog counts grant cycles already completed. The grant is aborted
  // at the end of the cycle that would be grant cycle number GRANT_TIMEOUT.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(GRANT_TIMEOUT - 1);

`ifdef SPRITE_DRAW_CLEAR_EN
  localparam logic [8:0] CLR_X_LAST = 9'd319;
  localparam logic [7:0] CLR_Y_LAST = 8'd239;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SPRITE_DRAW_CLEAR_EN
    S_CLEAR,
`endif
    S_SCAN,
    S_GRANT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] pending;
  logic [IDX_W-1:0]   sel;         // index of the currently granted source
  logic [IDX_W-1:0]   first_idx;   // lowest set bit of pending
  logic [WD_W-1:0]    wd;
  logic               sel_done;
  logic               wd_expired;

`ifdef SPRITE_DRAW_CLEAR_EN
  logic [8:0] clr_x;
  logic [7:0] clr_y;
  logic       clr_last;
  assign clr_last = (clr_x == CLR_X_LAST) && (clr_y == CLR_Y_LAST);
`endif

  // Priority encoder: the loop runs downward, so the lowest set index is the
  // one assigned last and it wins.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    first_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) first_idx = IDX_W'(i);
    end
  end

  // Done pulses from sources that do not hold the grant are ignored.
  assign sel_done   = src_done[sel];
  assign wd_expired = (wd == WD_LAST) && !sel_done;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (frame_tick) begin
`ifdef SPRITE_DRAW_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_SCAN;
`endif
        end
      end
`ifdef SPRITE_DRAW_CLEAR_EN
      S_CLEAR: if (clr_last) state_nxt = S_SCAN;
`endif
      S_SCAN:  state_nxt = (pending == '0) ? S_DONE : S_GRANT;
      S_GRANT: if (sel_done || wd_expired) state_nxt = S_SCAN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequential state
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous to clk. All state is cleared through this
    // branch, and all of it is made of plain flops, so no memory is left
    // without a reset.
    if (!resetn) begin
      state       <= S_IDLE;
      pending     <= '0;
      sel         <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
`ifdef SPRITE_DRAW_CLEAR_EN
      clr_x       <= '0;
      clr_y       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout the clocked block, so every
      // register samples the values from before the edge.
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (frame_tick) pending <= req;
`ifdef SPRITE_DRAW_CLEAR_EN
          clr_x <= '0;
          clr_y <= '0;
`endif
        end
`ifdef SPRITE_DRAW_CLEAR_EN
        S_CLEAR: begin
          if (clr_x == CLR_X_LAST) begin
            clr_x <= '0;
            clr_y <= clr_y + 8'd1;
          end else begin
            clr_x <= clr_x + 9'd1;
          end
        end
`endif
        S_SCAN: begin
          sel <= first_idx;
          wd  <= '0;
        end
        S_GRANT: begin
          wd <= wd + WD_W'(1);
          if (sel_done || wd_expired) pending[sel] <= 1'b0;
          if (wd_expired) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    grant      = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (state == S_GRANT) begin
      grant[sel] = 1'b1;
      vga_x      = src_x[9*sel +: 9];
      vga_y      = src_y[8*sel +: 8];
      vga_colour = src_colour[3*sel +: 3];
      vga_plot   = src_plot[sel];
    end
`ifdef SPRITE_DRAW_CLEAR_EN
    if (state == S_CLEAR) begin
      vga_x    = clr_x;
      vga_y    = clr_y;
      vga_plot = 1'b1;
    end
`endif
  end

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign overrun    = frame_tick && busy;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sprite_draw_scheduler
//
// Directed bench for sprite_draw_scheduler (NUM_SRC=4, GRANT_TIMEOUT=1023).
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time
// unit later, once the combinational mux has settled. Cycle counts are
// relative to the cycle in which frame_tick is high.
// -----------------------------------------------------------------------------
module tb_sprite_draw_scheduler;

  localparam int N  = 4;
  localparam int TO = 1023;

  logic           clk = 1'b0;
  logic           resetn;
  logic           frame_tick;
  logic [N-1:0]   req, src_done, src_plot, grant;
  logic [9*N-1:0] src_x;
  logic [8*N-1:0] src_y;
  logic [3*N-1:0] src_colour;
  logic [8:0]     vga_x;
  logic [7:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot, busy, frame_done, overrun, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_draw_scheduler #(.NUM_SRC(N), .GRANT_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .req(req),
    .src_done(src_done), .src_x(src_x), .src_y(src_y),
    .src_colour(src_colour), .src_plot(src_plot), .grant(grant),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hand-picked, distinct bus values per source.
  function automatic logic [8:0] sx(input int k); return 9'(10 + 50 * k); endfunction
  function automatic logic [7:0] sy(input int k); return 8'(5 + 20 * k);  endfunction
  function automatic logic [2:0] sc(input int k); return 3'(k + 1);       endfunction

  // Hold source k granted for n cycles, pulsing src_done in the last one.
  task automatic grant_phase(input int k, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) src_done = 4'(1 << k);
      #1;
      check({tag, "_grant"}, 32'(grant), 32'(1 << k));
      check({tag, "_x"}, 32'(vga_x), 32'(sx(k)));
      check({tag, "_y"}, 32'(vga_y), 32'(sy(k)));
      check({tag, "_col"}, 32'(vga_colour), 32'(sc(k)));
      check({tag, "_plot"}, 32'(vga_plot), 32'(1));
      cyc();
      src_done = '0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
  endtask

  int cnt;
  int col_bad;
  logic [8:0] last_x;
  logic [7:0] last_y;

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; req = '0; src_done = '0;
    src_plot = 4'b1111;
    for (int k = 0; k < N; k++) begin
      src_x[9*k +: 9]      = sx(k);
      src_y[8*k +: 8]      = sy(k);
      src_colour[3*k +: 3] = sc(k);
    end
    do_reset();
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_plot", 32'(vga_plot), 32'(0));
    check("rst_x", 32'(vga_x), 32'(0));
    check("rst_terr", 32'(timeout_err), 32'(0));
    check("rst_fdone", 32'(frame_done), 32'(0));
    cyc();

`ifdef SPRITE_DRAW_CLEAR_EN
    // Screen clear ahead of the single request.
    req = 4'b0001; frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0;
    cnt = 0; col_bad = 0; last_x = '0; last_y = '0;
    #1;
    while (vga_plot && cnt < 80000) begin
      if (vga_colour !== 3'b000 || grant !== '0) col_bad++;
      last_x = vga_x; last_y = vga_y; cnt++;
      cyc(); #1;
    end
    check("clr_cycles", 32'(cnt), 32'(76800));
    check("clr_colour_grant", 32'(col_bad), 32'(0));
    check("clr_last_x", 32'(last_x), 32'(319));
    check("clr_last_y", 32'(last_y), 32'(239));
    check("clr_scan_grant", 32'(grant), 32'(0));
    cyc(); #1;
    check("clr_then_grant", 32'(grant), 32'(4'b0001));
`else
    // Test 1: req=0101 (tick at t=10, so grant at 12, 22 and frame_done at 32).
    req = 4'b0101; frame_tick = 1'b1; #1;
    check("t1_tick_busy", 32'(busy), 32'(0));
    check("t1_tick_ovr", 32'(overrun), 32'(0));
    cyc(); frame_tick = 1'b0;
    req = 4'b1000;                  // post-snapshot changes are ignored
    #1;
    check("t1_scan_busy", 32'(busy), 32'(1));
    check("t1_scan_grant", 32'(grant), 32'(0));
    cyc();
    grant_phase(0, 9, "t1_s0");     // cycles 12..20
    #1;
    check("t1_gap_grant", 32'(grant), 32'(0));
    check("t1_gap_plot", 32'(vga_plot), 32'(0));
    cyc();
    grant_phase(2, 9, "t1_s2");     // cycles 22..30
    #1;
    check("t1_gap2_fdone", 32'(frame_done), 32'(0));
    cyc(); #1;
    check("t1_fdone", 32'(frame_done), 32'(1));
    check("t1_fdone_busy", 32'(busy), 32'(1));
    cyc(); #1;
    check("t1_idle_busy", 32'(busy), 32'(0));
    check("t1_idle_fdone", 32'(frame_done), 32'(0));
    cyc();

    // Test 2: no requests, so frame_done comes at t+2.
    req = '0; frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0; #1;
    check("t2_scan_fdone", 32'(frame_done), 32'(0));
    check("t2_scan_grant", 32'(grant), 32'(0));
    cyc(); #1;
    check("t2_fdone", 32'(frame_done), 32'(1));
    check("t2_grant", 32'(grant), 32'(0));
    check("t2_plot", 32'(vga_plot), 32'(0));
    cyc(); #1;
    check("t2_idle", 32'(busy), 32'(0));
    cyc();

    // Test 3: timeout on source 1.
    req = 4'b0010; frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0;
    cyc(); #1;
    cnt = 0;
    while (grant == 4'b0010 && cnt < 1100) begin
      cnt++;
      cyc(); #1;
    end
    check("t3_grant_len", 32'(cnt), 32'(TO));
    check("t3_terr", 32'(timeout_err), 32'(1));
    check("t3_grant_off", 32'(grant), 32'(0));
    cyc(); #1;
    check("t3_fdone", 32'(frame_done), 32'(1));
    cyc(); #1;
    check("t3_terr_sticky", 32'(timeout_err), 32'(1));
    check("t3_idle", 32'(busy), 32'(0));
    cyc();

    // Test 4: a tick during a grant pulses overrun and yields exactly one frame_done.
    req = 4'b0001; frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0;
    cyc(); cyc(); cyc();
    frame_tick = 1'b1; #1;
    check("t4_ovr", 32'(overrun), 32'(1));
    check("t4_ovr_grant", 32'(grant), 32'(4'b0001));
    cyc(); frame_tick = 1'b0; #1;
    check("t4_ovr_pulse", 32'(overrun), 32'(0));
    check("t4_grant_kept", 32'(grant), 32'(4'b0001));
    src_done = 4'b0001;
    cyc(); src_done = '0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (frame_done) cnt++;
      cyc();
    end
    check("t4_one_fdone", 32'(cnt), 32'(1));
    check("t4_idle", 32'(busy), 32'(0));

    // Test 5: isolation while source 1 is granted, then reset mid-grant.
    req = 4'b0010; frame_tick = 1'b1;
    cyc(); frame_tick = 1'b0;
    cyc();
    src_plot = 4'b1000; src_done = 4'b1000; #1;
    check("t5_iso_plot", 32'(vga_plot), 32'(0));
    check("t5_iso_x", 32'(vga_x), 32'(sx(1)));
    check("t5_iso_col", 32'(vga_colour), 32'(sc(1)));
    cyc();
    src_done = '0; src_plot = 4'b0010; #1;
    check("t5_iso_grant", 32'(grant), 32'(4'b0010));
    check("t5_iso_plot1", 32'(vga_plot), 32'(1));
    check("t5_terr_before", 32'(timeout_err), 32'(1));
    resetn = 1'b0; #1;
    check("t5_sync_rst", 32'(grant), 32'(4'b0010));
    cyc(); #1;
    check("t5_rst_grant", 32'(grant), 32'(0));
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_terr", 32'(timeout_err), 32'(0));
    resetn = 1'b1;
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
